// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: round-robin arbiter sharing one CBus port, grant held from request until the last beat.
package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [3:0]  len;
    logic [31:0] addr;
    logic [31:0] data;
  } cbus_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

module cbus_rr_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int IDX_W = $clog2(NUM_INPUTS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  cbus_req_t  [NUM_INPUTS-1:0] ireqs,
  output cbus_resp_t [NUM_INPUTS-1:0] iresps,
  output cbus_req_t                   oreq,
  input  cbus_resp_t                  oresp
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;
  logic [IDX_W-1:0] grant_idx, grant_nx, rr_ptr, rr_nx, win;
  logic found;
  int idx;
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = 0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
      if (!found && ireqs[idx].valid) begin
        found = 1'b1;
        win = IDX_W'(idx);
      end
    end
  end
  always_comb begin
    state_nx = state;
    grant_nx = grant_idx;
    rr_nx = rr_ptr;
    if (state == IDLE && found) begin
      state_nx = BUSY;
      grant_nx = win;
    end
    // explicit wrap keeps the pointer legal for non-power-of-2 requester counts
    if (state == BUSY && oresp.ready && oresp.last) begin
      state_nx = IDLE;
      rr_nx = (grant_idx == IDX_W'(NUM_INPUTS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
  always_comb begin
    oreq = (state == BUSY) ? ireqs[grant_idx] : '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      iresps[i] = (state == BUSY && grant_idx == IDX_W'(i)) ? oresp : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant_idx <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_nx;
      grant_idx <= grant_nx;
      rr_ptr <= rr_nx;
    end
  end
endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// tb_cbus_rr_arbiter: directed checks of grant order, burst locking, reset and stray responses.
module tb_cbus_rr_arbiter;
  import cbus_pkg::*;
  logic clk, reset;
  cbus_req_t  [1:0] ireqs;
  cbus_resp_t [1:0] iresps;
  cbus_req_t        oreq;
  cbus_resp_t       oresp;
  cbus_req_t  [2:0] ireqs3;
  cbus_resp_t [2:0] iresps3;
  cbus_req_t        oreq3;
  cbus_resp_t       oresp3;
  int total, bad;

  cbus_rr_arbiter #(.NUM_INPUTS(2)) dut (
    .clk(clk), .reset(reset), .ireqs(ireqs), .iresps(iresps), .oreq(oreq), .oresp(oresp));
  cbus_rr_arbiter #(.NUM_INPUTS(3)) dut3 (
    .clk(clk), .reset(reset), .ireqs(ireqs3), .iresps(iresps3), .oreq(oreq3), .oresp(oresp3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ireqs = '0;
    oresp = '0;
    ireqs3 = '0;
    oresp3 = '0;
  endtask

  function automatic cbus_req_t mk_req(input logic [31:0] addr);
    cbus_req_t r;
    r = '0;
    r.valid = 1'b1;
    r.len = 4'd3;
    r.addr = addr;
    r.data = addr ^ 32'h5a5a_0000;
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    ireqs[0] = mk_req(32'h10);
    oresp = '{ready: 1'b1, last: 1'b1, data: 32'h1};
    #1;
    total++;
    if (oreq !== '0) begin bad++; $display("FAIL reset_oreq got=%h want=0", oreq); end
    total++;
    if (iresps !== '0) begin bad++; $display("FAIL reset_iresps got=%h want=0", iresps); end
    total++;
    if (dut.rr_ptr !== 1'b0) begin bad++; $display("FAIL reset_rr_ptr got=%0d want=0", dut.rr_ptr); end
    clr();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single();
    test_reset();
    ireqs[1] = mk_req(32'h100);
    #1;
    total++;
    if (oreq.valid !== 1'b0) begin bad++; $display("FAIL single_idle valid got=%b want=0", oreq.valid); end
    tick();
    for (int b = 0; b < 4; b++) begin
      oresp = '{ready: 1'b1, last: (b == 3), data: 32'hd0 + b};
      #1;
      total++;
      if (oreq !== ireqs[1]) begin bad++; $display("FAIL single_oreq beat=%0d got=%h want=%h", b, oreq, ireqs[1]); end
      total++;
      if (iresps[1] !== oresp) begin bad++; $display("FAIL single_iresp1 beat=%0d got=%h want=%h", b, iresps[1], oresp); end
      total++;
      if (iresps[0] !== '0) begin bad++; $display("FAIL single_iresp0 beat=%0d got=%h want=0", b, iresps[0]); end
      tick();
    end
    clr();
    #1;
    total++;
    if (oreq.valid !== 1'b0) begin bad++; $display("FAIL single_done valid got=%b want=0", oreq.valid); end
    total++;
    if (dut.rr_ptr !== 1'b0) begin bad++; $display("FAIL single_rr_wrap got=%0d want=0", dut.rr_ptr); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] exp_addr;
    test_reset();
    ireqs[0] = mk_req(32'h200);
    ireqs[1] = mk_req(32'h204);
    oresp = '{ready: 1'b1, last: 1'b1, data: 32'hee};
    for (int c = 0; c < 8; c++) begin
      #1;
      total++;
      if (oreq.valid !== c[0]) begin bad++; $display("FAIL simul_valid cyc=%0d got=%b want=%b", c, oreq.valid, c[0]); end
      if (c[0]) begin
        exp_addr = (((c - 1) / 2) % 2 == 1) ? 32'h204 : 32'h200;
        total++;
        if (oreq.addr !== exp_addr) begin bad++; $display("FAIL simul_grant cyc=%0d got=%h want=%h", c, oreq.addr, exp_addr); end
        total++;
        if (iresps[exp_addr[2]] !== oresp || iresps[!exp_addr[2]] !== '0)
          begin bad++; $display("FAIL simul_iresps cyc=%0d got=%h", c, iresps); end
      end
      tick();
    end
    clr();
    tick();
  endtask

  task automatic test_lock();
    int beats;
    logic r;
    test_reset();
    ireqs[0] = mk_req(32'h300);
    ireqs[1] = mk_req(32'h304);
    ireqs[1].valid = 1'b0;
    tick();
    beats = 0;
    for (int k = 0; k < 40 && beats < 16; k++) begin
      r = (k % 3 != 2);
      oresp = '{ready: r, last: r && beats == 15, data: 32'(k)};
      #1;
      total++;
      if (oreq.valid !== 1'b1 || oreq.addr !== 32'h300)
        begin bad++; $display("FAIL lock_hold k=%0d got=%h want=300", k, oreq.addr); end
      if (r) beats++;
      if (beats == 10) ireqs[1].valid = 1'b1;
      tick();
    end
    total++;
    if (beats != 16) begin bad++; $display("FAIL lock_beats got=%0d want=16", beats); end
    oresp = '0;
    #1;
    total++;
    if (oreq.valid !== 1'b0) begin bad++; $display("FAIL lock_bubble got=%b want=0", oreq.valid); end
    tick();
    total++;
    if (oreq.valid !== 1'b1 || oreq.addr !== 32'h304)
      begin bad++; $display("FAIL lock_next got=%h want=304", oreq.addr); end
    oresp = '{ready: 1'b1, last: 1'b1, data: '0};
    tick();
    clr();
    tick();
  endtask

  task automatic test_non_pow2();
    logic [31:0] exp_addr;
    test_reset();
    for (int i = 0; i < 3; i++) ireqs3[i] = mk_req(32'h600 + 32'(i * 4));
    oresp3 = '{ready: 1'b1, last: 1'b1, data: 32'h77};
    for (int c = 0; c < 8; c++) begin
      #1;
      total++;
      if (oreq3.valid !== c[0]) begin bad++; $display("FAIL np2_valid cyc=%0d got=%b want=%b", c, oreq3.valid, c[0]); end
      if (c[0]) begin
        exp_addr = 32'h600 + 32'((((c - 1) / 2) % 3) * 4);
        total++;
        if (oreq3.addr !== exp_addr) begin bad++; $display("FAIL np2_grant cyc=%0d got=%h want=%h", c, oreq3.addr, exp_addr); end
      end
      total++;
      if (dut3.rr_ptr > 2'd2) begin bad++; $display("FAIL np2_rr_range cyc=%0d got=%0d want<3", c, dut3.rr_ptr); end
      tick();
    end
    clr();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    test_reset();
    ireqs[0] = mk_req(32'h400);
    tick();
    oresp = '{ready: 1'b1, last: 1'b0, data: 32'h1};
    tick();
    #1;
    total++;
    if (iresps[0] !== oresp) begin bad++; $display("FAIL rmb_beat2 got=%h want=%h", iresps[0], oresp); end
    reset = 1'b1;
    #1;
    total++;
    if (oreq.valid !== 1'b0) begin bad++; $display("FAIL rmb_oreq got=%b want=0", oreq.valid); end
    total++;
    if (iresps !== '0) begin bad++; $display("FAIL rmb_iresps got=%h want=0", iresps); end
    clr();
    ireqs[1] = mk_req(32'h404);
    tick();
    reset = 1'b0;
    #1;
    total++;
    if (oreq.valid !== 1'b0) begin bad++; $display("FAIL rmb_idle got=%b want=0", oreq.valid); end
    tick();
    total++;
    if (oreq.valid !== 1'b1 || oreq.addr !== 32'h404)
      begin bad++; $display("FAIL rmb_regrant got=%h want=404", oreq.addr); end
    oresp = '{ready: 1'b1, last: 1'b1, data: '0};
    tick();
    clr();
    tick();
  endtask

  task automatic test_stray();
    test_reset();
    ireqs[0] = mk_req(32'h500);
    tick();
    oresp = '{ready: 1'b1, last: 1'b1, data: 32'h5};
    tick();
    clr();
    oresp = '{ready: 1'b1, last: 1'b1, data: 32'hab};
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (iresps !== '0 || oreq.valid !== 1'b0)
        begin bad++; $display("FAIL stray_quiet cyc=%0d got=%h want=0", c, iresps); end
      total++;
      if (dut.rr_ptr !== 1'b1) begin bad++; $display("FAIL stray_rr cyc=%0d got=%0d want=1", c, dut.rr_ptr); end
      tick();
    end
    oresp = '0;
    ireqs[0] = mk_req(32'h500);
    ireqs[1] = mk_req(32'h504);
    tick();
    total++;
    if (oreq.addr !== 32'h504) begin bad++; $display("FAIL stray_next_grant got=%h want=504", oreq.addr); end
    oresp = '{ready: 1'b1, last: 1'b1, data: '0};
    tick();
    clr();
    tick();
  endtask

  initial begin
    total = 0;
    bad = 0;
    clr();
    test_reset();
    test_single();
    test_simultaneous();
    test_lock();
    test_non_pow2();
    test_reset_mid_burst();
    test_stray();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
